// File: rtl/tron_input_ctrl.sv
// Tron input conditioner: synchronizes and debounces BTN/SW, edge-detects them,
// and runs the game-control FSM and per-player heading registers.
module tron_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 400_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  BTN,
    input  logic [15:0] SW,
    input  logic        crash,
    output logic [1:0]  p1_dir,
    output logic [1:0]  p2_dir,
    output logic        p1_turn,
    output logic        p2_turn,
    output logic        game_clear,
    output logic        running
);

    localparam int unsigned NIN = 20;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    logic [NIN-1:0]   raw;
    logic [NIN-1:0]   meta_q;
    logic [NIN-1:0]   sync_q;
    logic [NIN-1:0]   deb_q;
    logic [NIN-1:0]   deb_d;
    logic [CNT_W-1:0] cnt_q [NIN];
    logic [CNT_W-1:0] cnt_d [NIN];

    // Edge detect only on consumed inputs: {p1 nibble, p2 nibble, start, pause, clear}
    logic [10:0] used_d;
    logic [10:0] used_dq_q;
    logic [10:0] rise;

    logic [1:0] state_q, state_d;
    logic [1:0] p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
    logic       p1_turn_q, p1_turn_d, p2_turn_q, p2_turn_d;
    logic       clear_q, clear_d, running_q, running_d;
    logic [2:0] h1, h2;

    assign raw    = {SW, BTN};
    assign used_d = {deb_q[19:16], deb_q[7:4], deb_q[3], deb_q[2], deb_q[0]};
    assign rise   = used_d & ~used_dq_q;

    always_comb begin
        for (int unsigned i = 0; i < NIN; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Returns {turn, new_dir}; nibble bit3..0 = UP, RIGHT, DOWN, LEFT
    function automatic logic [2:0] next_heading(input logic [3:0] rise_n, input logic [1:0] dir);
        logic [3:0] blocked;
        logic [3:0] cand;
        blocked = (4'b1000 >> dir) | (4'b1000 >> (dir ^ 2'b10));
        cand    = rise_n & ~blocked;
        if (cand[3])      next_heading = 3'b1_00;
        else if (cand[2]) next_heading = 3'b1_01;
        else if (cand[1]) next_heading = 3'b1_10;
        else if (cand[0]) next_heading = 3'b1_11;
        else              next_heading = {1'b0, dir};
    endfunction

    assign h1 = next_heading(rise[10:7], p1_dir_q);
    assign h2 = next_heading(rise[6:3], p2_dir_q);

    always_comb begin
        state_d   = state_q;
        p1_dir_d  = p1_dir_q;
        p2_dir_d  = p2_dir_q;
        p1_turn_d = 1'b0;
        p2_turn_d = 1'b0;
        clear_d   = 1'b0;
        if (rise[0]) begin
            state_d  = ST_IDLE;
            clear_d  = 1'b1;
            p1_dir_d = DIR_RIGHT;
            p2_dir_d = DIR_LEFT;
        end else begin
            case (state_q)
                ST_IDLE:  if (rise[2]) state_d = ST_RUN;
                ST_RUN: begin
                    if (crash) begin
                        state_d = ST_OVER;
                    end else if (rise[1]) begin
                        state_d = ST_PAUSE;
                    end else begin
                        p1_dir_d  = h1[1:0];
                        p1_turn_d = h1[2];
                        p2_dir_d  = h2[1:0];
                        p2_turn_d = h2[2];
                    end
                end
                ST_PAUSE: if (rise[1]) state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            used_dq_q <= '0;
            for (int unsigned i = 0; i < NIN; i++) cnt_q[i] <= '0;
            state_q   <= ST_IDLE;
            p1_dir_q  <= DIR_RIGHT;
            p2_dir_q  <= DIR_LEFT;
            p1_turn_q <= 1'b0;
            p2_turn_q <= 1'b0;
            clear_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            meta_q    <= raw;
            sync_q    <= meta_q;
            deb_q     <= deb_d;
            used_dq_q <= used_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            p1_dir_q  <= p1_dir_d;
            p2_dir_q  <= p2_dir_d;
            p1_turn_q <= p1_turn_d;
            p2_turn_q <= p2_turn_d;
            clear_q   <= clear_d;
            running_q <= running_d;
        end
    end

    assign p1_dir     = p1_dir_q;
    assign p2_dir     = p2_dir_q;
    assign p1_turn    = p1_turn_q;
    assign p2_turn    = p2_turn_q;
    assign game_clear = clear_q;
    assign running    = running_q;

endmodule

// File: tb/tb_tron_input_ctrl.sv
// Bench for tron_input_ctrl: directed scenarios plus random stimulus, all outputs
// compared every cycle against a sliding-window debounce and game-rule model.
module tb_tron_input_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  BTN;
    logic [15:0] SW;
    logic        crash;
    logic [1:0]  p1_dir, p2_dir;
    logic        p1_turn, p2_turn, game_clear, running;

    tron_input_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .BTN        (BTN),
        .SW         (SW),
        .crash      (crash),
        .p1_dir     (p1_dir),
        .p2_dir     (p2_dir),
        .p1_turn    (p1_turn),
        .p2_turn    (p2_turn),
        .game_clear (game_clear),
        .running    (running)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_OVER} mstate_t;
    mstate_t     m_st;
    logic [1:0]  m_d1, m_d2;
    logic        m_t1, m_t2, m_clr, m_run;
    logic [19:0] m_deb, m_debq;
    logic [19:0] m_delay[$];
    logic [19:0] m_win[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_d1 = 2'd1; m_d2 = 2'd3;
        m_t1 = 0; m_t2 = 0; m_clr = 0; m_run = 0;
        m_deb = '0; m_debq = '0;
        m_delay.delete(); m_delay.push_back('0); m_delay.push_back('0);
        m_win.delete();
    endtask

    // Headings 0..3 = UP, RIGHT, DOWN, LEFT; the reverse of h is (h+2) mod 4
    task automatic heading(input logic [3:0] nib, input logic [1:0] dir,
                           output logic [1:0] nd, output logic turned);
        nd = dir; turned = 0;
        for (int h = 0; h < 4; h++) begin
            if (!turned && nib[3-h] && h != int'(dir) && h != (int'(dir) + 2) % 4) begin
                nd = 2'(h); turned = 1;
            end
        end
    endtask

    task automatic model_step();
        logic [19:0] rise, s_pre;
        logic [1:0]  nd;
        logic        tn, all_inv;
        rise = m_deb & ~m_debq;
        m_t1 = 0; m_t2 = 0; m_clr = 0;
        if (rise[0]) begin
            m_st = M_IDLE; m_clr = 1; m_d1 = 2'd1; m_d2 = 2'd3;
        end else begin
            case (m_st)
                M_IDLE:  if (rise[3]) m_st = M_RUN;
                M_RUN: begin
                    if (crash) m_st = M_OVER;
                    else if (rise[2]) m_st = M_PAUSE;
                    else begin
                        heading(rise[19:16], m_d1, nd, tn); m_d1 = nd; m_t1 = tn;
                        heading(rise[7:4],   m_d2, nd, tn); m_d2 = nd; m_t2 = tn;
                    end
                end
                M_PAUSE: if (rise[2]) m_st = M_RUN;
                default: ;
            endcase
        end
        m_run = (m_st == M_RUN);
        m_debq = m_deb;
        // Debounced bit flips once the last N synchronized samples all disagree with it
        s_pre = m_delay.pop_front();
        m_delay.push_back({SW, BTN});
        m_win.push_back(s_pre);
        if (m_win.size() > N) void'(m_win.pop_front());
        if (m_win.size() == N) begin
            for (int i = 0; i < 20; i++) begin
                all_inv = 1;
                foreach (m_win[k]) if (m_win[k][i] == m_deb[i]) all_inv = 0;
                if (all_inv) m_deb[i] = ~m_deb[i];
            end
        end
    endtask

    task automatic check_outputs();
        chk("p1_dir", p1_dir, m_d1);
        chk("p2_dir", p2_dir, m_d2);
        chk("p1_turn", p1_turn, m_t1);
        chk("p2_turn", p2_turn, m_t2);
        chk("game_clear", game_clear, m_clr);
        chk("running", running, m_run);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        int t1, t2, nclr;
        logic [19:0] v;
        int idx;

        // Reset with all switches high, before any clock edge
        reset = 1'b1; BTN = '0; SW = 16'hFFFF; crash = 1'b0;
        model_reset();
        #2;
        chk("rst_p1_dir", p1_dir, 2'b01);
        chk("rst_p2_dir", p2_dir, 2'b11);
        chk("rst_running", running, 0);
        chk("rst_pulses", {p1_turn, p2_turn, game_clear}, 3'b000);
        #2 reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("idle_running", running, 0);
            chk("idle_dirs", {p1_dir, p2_dir}, 4'b0111);
        end
        SW = '0;
        repeat (N + 4) tick();

        // Bounce on start button, then settle high
        for (int i = 0; i < 12; i++) begin
            BTN[3] = ((i / 2) % 2 == 0);
            tick();
            chk("bounce_early", running, 0);
        end
        BTN[3] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("bounce_start", running, (k == 6));
        end
        BTN[3] = 1'b0;
        repeat (N + 4) tick();
        chk("start_fall_ignored", running, 1);

        // Reverse of RIGHT (LEFT) is rejected, then UP is taken
        SW[12] = 1'b1;
        for (int k = 0; k < N + 4; k++) begin
            tick();
            chk("rev_dir", p1_dir, 2'b01);
            chk("rev_turn", p1_turn, 0);
        end
        SW[15] = 1'b1;
        t1 = 0;
        for (int k = 0; k < N + 4; k++) begin tick(); t1 += p1_turn; end
        chk("up_turns", t1, 1);
        chk("up_dir", p1_dir, 2'b00);

        // p2 heading LEFT: RIGHT (reverse) and DOWN rise together -> DOWN
        SW[2] = 1'b1; SW[1] = 1'b1;
        t1 = 0; t2 = 0;
        for (int k = 0; k < N + 4; k++) begin tick(); t1 += p1_turn; t2 += p2_turn; end
        chk("prio_p2_turns", t2, 1);
        chk("prio_p2_dir", p2_dir, 2'b10);
        chk("prio_p1_turns", t1, 0);
        chk("prio_p1_dir", p1_dir, 2'b00);

        // Crash in the same cycle as a pause rise
        BTN[2] = 1'b1;
        repeat (N + 2) tick();
        chk("pre_crash_running", running, 1);
        crash = 1'b1;
        tick();
        crash = 1'b0;
        chk("crash_running", running, 0);
        BTN[2] = 1'b0; repeat (N + 4) tick();
        BTN[2] = 1'b1; repeat (N + 4) tick();
        chk("over_pause_ignored", running, 0);
        BTN[3] = 1'b1; repeat (N + 4) tick();
        chk("over_start_ignored", running, 0);
        BTN[0] = 1'b1;
        nclr = 0;
        for (int k = 0; k < N + 4; k++) begin tick(); nclr += game_clear; end
        chk("clear_pulses", nclr, 1);
        chk("clear_dirs", {p1_dir, p2_dir}, 4'b0111);
        chk("clear_running", running, 0);

        // Async reset in the middle of a debounce
        BTN = '0; SW = '0;
        repeat (N + 4) tick();
        SW[14] = 1'b1;
        tick(); tick();
        async_reset_pulse();
        chk("midrst_d", dut.deb_q[18], 0);
        chk("midrst_cnt", 32'(dut.cnt_q[18]), 0);
        for (int k = 0; k < N + 2; k++) begin
            tick();
            chk("relatch_d", dut.deb_q[18], (k == N + 1));
        end

        // Random toggling against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, 19);
                if (idx != 0 || $urandom_range(0, 7) == 0) begin
                    v = {SW, BTN};
                    v[idx] = ~v[idx];
                    {SW, BTN} = v;
                end
            end
            crash = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
